// File: rtl/aes_port_arbiter_pkg.sv
// ============================================================================
// Module : aes_arb_pkg
// Desc   : Shared types and AES core register map for the AES port arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package aes_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam logic [7:0] AES_CTRL        = 8'h08;
  localparam logic [7:0] AES_STATUS      = 8'h09;
  localparam logic [7:0] AES_KEY_BASE    = 8'h10;
  localparam logic [7:0] AES_BLOCK_BASE  = 8'h20;
  localparam logic [7:0] AES_RESULT_BASE = 8'h30;

endpackage

`default_nettype wire

// File: rtl/aes_port_arbiter_if.sv
// ============================================================================
// Module : aes_port_arbiter_if
// Desc   : Requester-side bundle of the AES port arbiter (flattened per-requester buses).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface aes_port_arbiter_if #(
  parameter int NREQ = 2
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_i;
  logic [NREQ-1:0]    cs_i;
  logic [NREQ-1:0]    we_i;
  logic [8*NREQ-1:0]  addr_i;
  logic [32*NREQ-1:0] wdata_i;
  logic [NREQ-1:0]    gnt_o;
  logic [31:0]        rdata_o;
  logic [IDX_W-1:0]   owner_o;
  logic               busy_o;
  logic               timeout_o;

  modport master (
    output req_i, cs_i, we_i, addr_i, wdata_i,
    input  gnt_o, rdata_o, owner_o, busy_o, timeout_o
  );

  modport slave (
    input  req_i, cs_i, we_i, addr_i, wdata_i,
    output gnt_o, rdata_o, owner_o, busy_o, timeout_o
  );

endinterface

`default_nettype wire

// File: rtl/aes_port_arbiter_rr_arb_pick.sv
// ============================================================================
// Module : rr_arb_pick
// Desc   : Combinational round-robin picker; searches ptr+1, ptr+2, ... modulo NREQ.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arb_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  wire logic [NREQ-1:0]  req_i,
  input  wire logic [IDX_W-1:0] ptr_i,
  output logic                  valid_o,
  output logic [IDX_W-1:0]      idx_o
);

  localparam int               CW     = IDX_W + 1;
  localparam logic [CW-1:0]    c_nreq = CW'(NREQ);

  logic [CW-1:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    w_cand  = '0;
    for (int i = NREQ; i >= 1; i--) begin
      w_cand = {1'b0, ptr_i} + CW'(i);
      if (w_cand >= c_nreq) begin
        w_cand = w_cand - c_nreq;
      end
      if (req_i[w_cand[IDX_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/aes_port_arbiter.sv
// ============================================================================
// Module : aes_port_arbiter
// Desc   : Lock-based round-robin sharing of the AES register port with hold watchdog.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aes_port_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int IDLE_TIMEOUT = 256
) (
  input  wire logic           clk_i,
  input  wire logic           rst_ni,
  aes_port_arbiter_if.slave   bus,
  output logic                aes_cs,
  output logic                aes_we,
  output logic [7:0]          aes_address,
  output logic [31:0]         aes_write_data,
  input  wire logic [31:0]    aes_read_data
);

  localparam int          IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] c_timeout = 16'(IDLE_TIMEOUT);
  localparam bit          c_wdog_en = (IDLE_TIMEOUT != 0);

  arb_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_owner, w_owner_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [15:0]      r_wdog, w_wdog_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic             w_timeout;
  logic             w_pick_valid;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_owner_req;
  logic [7:0]       w_addr  [NREQ];
  logic [31:0]      w_wdata [NREQ];

  for (genvar n = 0; n < NREQ; n++) begin : g_unpack
    assign w_addr[n]  = bus.addr_i[8*n +: 8];
    assign w_wdata[n] = bus.wdata_i[32*n +: 32];
  end

  rr_arb_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (bus.req_i),
    .ptr_i   (r_ptr),
    .valid_o (w_pick_valid),
    .idx_o   (w_pick_idx)
  );

  // Gating by the owner's own req drops an access issued on the release cycle.
  assign w_owner_req    = (r_state == OWN) && bus.req_i[r_owner];
  assign aes_cs         = w_owner_req && bus.cs_i[r_owner];
  assign aes_we         = aes_cs && bus.we_i[r_owner];
  assign aes_address    = aes_cs ? w_addr[r_owner]  : 8'h00;
  assign aes_write_data = aes_cs ? w_wdata[r_owner] : 32'h0;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_wdog_nxt  = r_wdog;
    w_timeout   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_nxt = OWN;
          w_owner_nxt = w_pick_idx;
          w_wdog_nxt  = '0;
        end
      end
      OWN: begin
        if (!w_owner_req) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_owner;
        end else if (aes_cs) begin
          w_wdog_nxt  = '0;
        end else if (c_wdog_en && (r_wdog + 16'd1 == c_timeout)) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_owner;
          w_wdog_nxt  = '0;
          w_timeout   = 1'b1;
        end else begin
          w_wdog_nxt  = r_wdog + 16'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_gnt_nxt = '0;
    if (w_state_nxt == OWN) begin
      w_gnt_nxt[w_owner_nxt] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= IDX_W'(NREQ - 1);
      r_wdog  <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_wdog  <= w_wdog_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign bus.gnt_o     = r_gnt;
  assign bus.busy_o    = (r_state == OWN);
  assign bus.owner_o   = r_owner;
  assign bus.timeout_o = w_timeout;
  assign bus.rdata_o   = aes_read_data;

endmodule

`default_nettype wire

// File: tb/tb_aes_port_arbiter.sv
// ============================================================================
// Module : tb_aes_port_arbiter
// Desc   : Scoreboard bench for aes_port_arbiter against a cycle-level lock model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_aes_port_arbiter;
  import aes_arb_pkg::*;

  localparam int N  = 2;
  localparam int TO = 4;
  localparam int IW = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aes_cs, aes_we;
  logic [7:0]  aes_address;
  logic [31:0] aes_write_data, aes_read_data;

  aes_port_arbiter_if #(.NREQ(N)) bus ();

  aes_port_arbiter #(
    .NREQ         (N),
    .IDLE_TIMEOUT (TO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .bus            (bus.slave),
    .aes_cs         (aes_cs),
    .aes_we         (aes_we),
    .aes_address    (aes_address),
    .aes_write_data (aes_write_data),
    .aes_read_data  (aes_read_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic          busy;
    logic [IW-1:0] owner;
    logic          timeout;
    logic          cs;
    logic [31:0]   rdata;
  } stat_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } acc_t;

  stat_t stat_q[$];
  acc_t  acc_q[$];
  stat_t mon_s;
  acc_t  mon_a;
  int    total = 0;
  int    bad   = 0;

  // Reference model: who holds the lock, where the rotation resumes, idle owned cycles.
  bit m_busy;
  int m_owner, m_ptr, m_idle;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = N - 1;
    m_idle  = 0;
  endtask

  // Applies one cycle of inputs, predicts this cycle's outputs, then advances the model.
  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] cs, input logic [N-1:0] we,
                       input logic [8*N-1:0] addr, input logic [32*N-1:0] wdata);
    stat_t       s;
    acc_t        a;
    bit          acc;
    logic [31:0] rd;
    rd            = $urandom;
    bus.req_i     = req;
    bus.cs_i      = cs;
    bus.we_i      = we;
    bus.addr_i    = addr;
    bus.wdata_i   = wdata;
    aes_read_data = rd;

    acc = m_busy && req[m_owner] && cs[m_owner];
    s.gnt = '0;
    if (m_busy) s.gnt[m_owner] = 1'b1;
    s.busy    = m_busy;
    s.owner   = IW'(m_owner);
    s.cs      = acc;
    s.rdata   = rd;
    s.timeout = m_busy && req[m_owner] && !acc && (m_idle + 1 == TO);
    stat_q.push_back(s);
    if (acc) begin
      a.we    = we[m_owner];
      a.addr  = addr[8*m_owner +: 8];
      a.wdata = wdata[32*m_owner +: 32];
      acc_q.push_back(a);
    end

    if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (req[j]) begin
          m_busy  = 1'b1;
          m_owner = j;
          m_idle  = 0;
          break;
        end
      end
    end else if (!req[m_owner]) begin
      m_busy = 1'b0;
      m_ptr  = m_owner;
    end else if (acc) begin
      m_idle = 0;
    end else if (m_idle + 1 == TO) begin
      m_busy = 1'b0;
      m_ptr  = m_owner;
    end else begin
      m_idle++;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (stat_q.size() > 0) begin
      mon_s = stat_q.pop_front();
      check("gnt", 64'(bus.gnt_o), 64'(mon_s.gnt));
      check("busy", 64'(bus.busy_o), 64'(mon_s.busy));
      if (mon_s.busy) check("owner", 64'(bus.owner_o), 64'(mon_s.owner));
      check("timeout", 64'(bus.timeout_o), 64'(mon_s.timeout));
      check("aes_cs", 64'(aes_cs), 64'(mon_s.cs));
      check("rdata", 64'(bus.rdata_o), 64'(mon_s.rdata));
      if (aes_cs === 1'b1) begin
        if (acc_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL access: got unexpected AES access addr %0h, required none", aes_address);
        end else begin
          mon_a = acc_q.pop_front();
          check("aes_we", 64'(aes_we), 64'(mon_a.we));
          check("aes_address", 64'(aes_address), 64'(mon_a.addr));
          check("aes_write_data", 64'(aes_write_data), 64'(mon_a.wdata));
        end
      end else begin
        check("gated_we", 64'(aes_we), 64'(0));
        check("gated_addr", 64'(aes_address), 64'(0));
        check("gated_wdata", 64'(aes_write_data), 64'(0));
      end
    end
  end

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(4))
      0:       return AES_CTRL;
      1:       return AES_STATUS;
      2:       return AES_KEY_BASE + 8'($urandom_range(7));
      3:       return AES_BLOCK_BASE + 8'($urandom_range(3));
      default: return AES_RESULT_BASE + 8'($urandom_range(3));
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0]    rreq, rcs, rwe;
    logic [8*N-1:0]  raddr;
    logic [32*N-1:0] rwdata;

    rst_n         = 1'b0;
    bus.req_i     = '0;
    bus.cs_i      = '0;
    bus.we_i      = '0;
    bus.addr_i    = '0;
    bus.wdata_i   = '0;
    aes_read_data = '0;
    model_reset();

    repeat (2) @(posedge clk);
    bus.req_i = 2'b11;
    bus.cs_i  = 2'b11;
    @(negedge clk);
    check("rst_gnt", 64'(bus.gnt_o), 64'(0));
    check("rst_busy", 64'(bus.busy_o), 64'(0));
    check("rst_owner", 64'(bus.owner_o), 64'(0));
    check("rst_timeout", 64'(bus.timeout_o), 64'(0));
    check("rst_aes_cs", 64'(aes_cs), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single requester write to CTRL.
    drive(2'b01, 2'b00, 2'b00, '0, '0);
    drive(2'b01, 2'b01, 2'b01, {8'h00, AES_CTRL}, {32'h0, 32'h1});
    drive(2'b00, 2'b00, 2'b00, '0, '0);
    drive(2'b00, 2'b00, 2'b00, '0, '0);

    // Both requesting: alternation through an idle cycle.
    repeat (3) begin
      drive(2'b11, 2'b00, 2'b00, '0, '0);
      drive(2'b11, 2'b01, 2'b00, {AES_STATUS, AES_STATUS}, '0);
      drive(2'b10, 2'b00, 2'b00, '0, '0);
      drive(2'b11, 2'b10, 2'b10, {AES_KEY_BASE, 8'h00}, {32'hCAFE_F00D, 32'h0});
      drive(2'b01, 2'b00, 2'b00, '0, '0);
    end
    drive(2'b00, 2'b00, 2'b00, '0, '0);
    drive(2'b00, 2'b00, 2'b00, '0, '0);

    // Non-owner chip select is ignored.
    drive(2'b01, 2'b00, 2'b00, '0, '0);
    drive(2'b11, 2'b10, 2'b10, {AES_RESULT_BASE, 8'h00}, {32'h1234_5678, 32'h0});

    // Owner holds the lock without accessing: watchdog revocation.
    repeat (8) drive(2'b01, 2'b00, 2'b00, '0, '0);
    drive(2'b00, 2'b00, 2'b00, '0, '0);
    drive(2'b00, 2'b00, 2'b00, '0, '0);

    // Access on the release cycle is dropped.
    drive(2'b01, 2'b00, 2'b00, '0, '0);
    drive(2'b01, 2'b01, 2'b01, {8'h00, AES_BLOCK_BASE}, {32'h0, 32'hAAAA_5555});
    drive(2'b00, 2'b01, 2'b01, {8'h00, AES_CTRL}, {32'h0, 32'h1});
    drive(2'b00, 2'b00, 2'b00, '0, '0);

    rreq = '0;
    repeat (1500) begin
      for (int n = 0; n < N; n++) begin
        if (rreq[n]) begin
          if ($urandom_range(9) == 0) rreq[n] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          rreq[n] = 1'b1;
        end
        rcs[n]               = ($urandom_range(9) < 6);
        rwe[n]               = $urandom_range(1) == 1;
        raddr[8*n +: 8]      = rand_addr();
        rwdata[32*n +: 32]   = $urandom;
      end
      drive(rreq, rcs, rwe, raddr, rwdata);
    end

    // Reset during an active access.
    drive(2'b00, 2'b00, 2'b00, '0, '0);
    drive(2'b00, 2'b00, 2'b00, '0, '0);
    drive(2'b01, 2'b00, 2'b00, '0, '0);
    bus.req_i   = 2'b01;
    bus.cs_i    = 2'b01;
    bus.we_i    = 2'b01;
    bus.addr_i  = {8'h00, AES_KEY_BASE};
    bus.wdata_i = {32'h0, 32'hDEAD_BEEF};
    #1;
    check("pre_rst_aes_cs", 64'(aes_cs), 64'(1));
    check("pre_rst_gnt", 64'(bus.gnt_o), 64'(2'b01));
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_aes_cs", 64'(aes_cs), 64'(0));
    check("mid_rst_addr", 64'(aes_address), 64'(0));
    check("mid_rst_gnt", 64'(bus.gnt_o), 64'(0));
    check("mid_rst_busy", 64'(bus.busy_o), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive(2'b11, 2'b00, 2'b00, '0, '0);
    drive(2'b11, 2'b11, 2'b11, {AES_CTRL, AES_STATUS}, {32'h2, 32'h3});
    drive(2'b11, 2'b00, 2'b00, '0, '0);

    check("acc_queue_drained", 64'(acc_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
